// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx byte interface
// among NUM_REQ requesters. A grant is held for a whole packet (until the
// byte flagged req_last) or until MAX_BURST bytes have gone out (0 = no limit).
//
// Build option: define ARB_HDR_EN to emit a header byte (8'hA0 | grant_id)
// before the first byte of every grant. Without it, IDLE goes straight to LOCKED.
//
// Handshake: a byte moves on a rising clk edge where valid and ready are both
// high; a requester holds data/last/valid stable until it sees ready.
// dbg_state exposes the FSM state register for checkers.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 0,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_LAST = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [ID_W-1:0] RR_RESET   = ID_W'(NUM_REQ - 1);

`ifdef ARB_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_HDR    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic [ID_W-1:0] cand;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic            xfer;
    logic            release_now;

    // Granted requester's view; the grant index selects one byte lane
    always_comb begin
        g_valid     = req_valid[grant_q];
        g_last      = req_last[grant_q];
        g_data      = req_data[{grant_q, 3'b000} +: 8];
        xfer        = (state_q == ST_LOCKED) && g_valid && tx_ready;
        release_now = xfer && (g_last || ((MAX_BURST != 0) && (burst_cnt_q == BURST_LAST)));
    end

    // Round-robin search: first valid requester above rr_ptr, wrapping
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State register and grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= RR_RESET;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state: grant from IDLE, release on last byte or burst limit
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
`ifdef ARB_HDR_EN
                    state_d     = ST_HDR;
`else
                    state_d     = ST_LOCKED;
`endif
                end
            end
`ifdef ARB_HDR_EN
            ST_HDR: begin
                // Header byte is not counted toward the burst
                if (tx_ready) begin
                    state_d = ST_LOCKED;
                end
            end
`endif
            ST_LOCKED: begin
                if (release_now) begin
                    rr_ptr_d    = grant_q;
                    burst_cnt_d = '0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs: LOCKED is a combinational pass-through of the granted requester
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (state_q)
            ST_LOCKED: begin
                tx_valid           = g_valid;
                tx_data            = g_data;
                req_ready[grant_q] = tx_ready;
            end
`ifdef ARB_HDR_EN
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 | (8'(grant_q) & 8'h0F);
            end
`endif
            default: begin
                tx_valid  = 1'b0;
                tx_data   = 8'h00;
                req_ready = '0;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: bench for uart_tx_arbiter. Two instances share the
// request inputs: dut_a with unlimited bursts, dut_b with MAX_BURST=2.
// Expected transmit order comes from a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef ARB_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic           tx_ready;

    logic [N-1:0] rr_a, rr_b;
    logic [7:0]   txd_a, txd_b;
    logic         txv_a, txv_b;
    logic [1:0]   gid_a, gid_b;
    logic         busy_a, busy_b;
    logic [1:0]   st_a, st_b;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(0), .ID_W(2)) dut_a (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(rr_a), .tx_data(txd_a), .tx_valid(txv_a),
        .tx_ready(tx_ready), .grant_id(gid_a), .busy(busy_a), .dbg_state(st_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .ID_W(2)) dut_b (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(rr_b), .tx_data(txd_b), .tx_valid(txv_b),
        .tx_ready(tx_ready), .grant_id(gid_b), .busy(busy_b), .dbg_state(st_b)
    );

    int tests = 0;
    int fails = 0;

    // Requester packet storage
    logic [7:0] pd[N][32];
    logic       pl[N][32];
    int         cnt[N];
    int         rd[N];

    // Scoreboard: {is_header, id[1:0], byte}
    logic [10:0] exp_q[$];
    int          xfer_cyc[$];
    logic [7:0]  xfer_byte[$];
    logic [7:0]  data_byte[$];
    logic [1:0]  data_id[$];
    logic        rdy_pat[$];

    task automatic drive_idle();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_pkts();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            rd[i]  = 0;
        end
        exp_q.delete();
        xfer_cyc.delete();
        xfer_byte.delete();
        data_byte.delete();
        data_id.delete();
        rdy_pat.delete();
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        pd[r][cnt[r]] = d;
        pl[r][cnt[r]] = l;
        cnt[r]++;
    endtask

    // Reference model: requesters stay valid while they have bytes, so each
    // grant goes to the next requester after the last releaser that still has
    // bytes; a grant covers one packet, cut short at mb bytes when mb != 0.
    task automatic build_exp(input int mb);
        int  pos[N];
        int  rr;
        int  idx;
        int  n;
        logic l;
        for (int i = 0; i < N; i++) pos[i] = 0;
        rr = N - 1;
        exp_q.delete();
        forever begin
            idx = -1;
            for (int i = 1; i <= N; i++) begin
                if (idx < 0 && pos[(rr + i) % N] < cnt[(rr + i) % N]) idx = (rr + i) % N;
            end
            if (idx < 0) break;
`ifdef ARB_HDR_EN
            exp_q.push_back({1'b1, 2'(idx), 8'hA0 | 8'(idx)});
`endif
            n = 0;
            do begin
                exp_q.push_back({1'b0, 2'(idx), pd[idx][pos[idx]]});
                l = pl[idx][pos[idx]];
                pos[idx]++;
                n++;
            end while (!(l || (mb != 0 && n == mb)));
            rr = idx;
        end
    endtask

    // Driver + monitor: present queue heads, pick tx_ready by mode
    // (0 always, 1 random, 2 pattern), and check every cycle on the scoreboard.
    task automatic run_stream(input int sel, input int mode, input int stop_after);
        int         cyc;
        int         nx;
        bit         done;
        logic [3:0] o_rr;
        logic [7:0] o_d;
        logic       o_v;
        logic       o_b;
        logic [1:0] o_g;
        logic [10:0] e;
        logic [3:0] exp_rr;
        cyc  = 0;
        nx   = 0;
        done = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rd[i] < cnt[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = pd[i][rd[i]];
                    req_last[i]        = pl[i][rd[i]];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (cyc < rdy_pat.size()) ? rdy_pat[cyc] : 1'b1;
            endcase
            #1;
            if (sel == 0) begin
                o_rr = rr_a; o_d = txd_a; o_v = txv_a; o_g = gid_a; o_b = busy_a;
            end else begin
                o_rr = rr_b; o_d = txd_b; o_v = txv_b; o_g = gid_b; o_b = busy_b;
            end
            if (o_v) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_tx: tx_data=%h while nothing expected (cycle %0d)", o_d, cyc);
                    done = 1;
                end else begin
                    e = exp_q[0];
                    tests++;
                    if (o_d !== e[7:0]) begin
                        fails++;
                        $display("FAIL tx_data: got %h expected %h (cycle %0d)", o_d, e[7:0], cyc);
                    end
                    exp_rr = (e[10] || !tx_ready) ? 4'b0000 : (4'b0001 << e[9:8]);
                    tests++;
                    if (o_rr !== exp_rr) begin
                        fails++;
                        $display("FAIL req_ready: got %b expected %b (cycle %0d)", o_rr, exp_rr, cyc);
                    end
                    if (tx_ready) begin
                        tests++;
                        if (o_g !== e[9:8]) begin
                            fails++;
                            $display("FAIL grant_id: got %0d expected %0d (cycle %0d)", o_g, e[9:8], cyc);
                        end
                        tests++;
                        if (o_b !== 1'b1) begin
                            fails++;
                            $display("FAIL busy_xfer: got %b expected 1 (cycle %0d)", o_b, cyc);
                        end
                        xfer_cyc.push_back(cyc);
                        xfer_byte.push_back(o_d);
                        if (!e[10]) begin
                            data_byte.push_back(o_d);
                            data_id.push_back(o_g);
                        end
                        void'(exp_q.pop_front());
                        nx++;
                    end
                end
            end else begin
                tests++;
                if (o_rr !== 4'b0000) begin
                    fails++;
                    $display("FAIL req_ready_idle: got %b expected 0000 (cycle %0d)", o_rr, cyc);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && o_rr[i] && tx_ready) rd[i]++;
            end
            if (stop_after >= 0) begin
                if (nx == stop_after) done = 1;
            end else if (exp_q.size() == 0) begin
                done = 1;
            end
            cyc++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: stream stalled with %0d bytes still expected", exp_q.size());
        end
    endtask

    task automatic test_reset();
        // Park dut_a mid-grant on requester 2, then reset over a live request
        req_valid          = 4'b0100;
        req_data[8*2 +: 8] = 8'h5A;
        req_last[2]        = 1'b0;
        tx_ready           = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++; if (txv_a !== 1'b0)   begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", txv_a); end
        tests++; if (txd_a !== 8'h00)  begin fails++; $display("FAIL reset_tx_data: got %h expected 00", txd_a); end
        tests++; if (rr_a !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", rr_a); end
        tests++; if (gid_a !== 2'd0)   begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", gid_a); end
        tests++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        tests++; if (busy_b !== 1'b0)  begin fails++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes[3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        clear_pkts();
        for (int k = 0; k < 3; k++) add_byte(0, bytes[k], k == 2);
        build_exp(0);
        run_stream(0, 0, -1);
        tests++;
        if (xfer_cyc.size() != 3 + H) begin
            fails++; $display("FAIL single_count: got %0d expected %0d", xfer_cyc.size(), 3 + H);
        end
        for (int k = 0; k < xfer_cyc.size() && k < 3 + H; k++) begin
            tests++;
            if (xfer_cyc[k] != 1 + k) begin
                fails++; $display("FAIL single_timing[%0d]: got cycle %0d expected %0d", k, xfer_cyc[k], 1 + k);
            end
        end
        for (int k = 0; k < data_byte.size() && k < 3; k++) begin
            tests++;
            if (data_byte[k] !== bytes[k]) begin
                fails++; $display("FAIL single_byte[%0d]: got %h expected %h", k, data_byte[k], bytes[k]);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b expected 0", busy_a); end
        tests++; if (txv_a !== 1'b0)  begin fails++; $display("FAIL single_idle_after: got %b expected 0", txv_a); end
    endtask

    task automatic test_round_robin();
        int         exp_c;
        logic [7:0] exp_b;
        do_reset();
        clear_pkts();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) add_byte(i, 8'h40 + 8'(i), 1'b1);
        build_exp(0);
        run_stream(0, 0, -1);
        tests++;
        if (xfer_cyc.size() != 8 * (1 + H)) begin
            fails++; $display("FAIL rr_count: got %0d expected %0d", xfer_cyc.size(), 8 * (1 + H));
        end
        for (int k = 0; k < xfer_cyc.size() && k < 8 * (1 + H); k++) begin
`ifdef ARB_HDR_EN
            exp_c = 1 + 3 * (k / 2) + (k % 2);
            exp_b = (k % 2 == 0) ? (8'hA0 | 8'((k / 2) % 4)) : (8'h40 + 8'((k / 2) % 4));
`else
            exp_c = 1 + 2 * k;
            exp_b = 8'h40 + 8'(k % 4);
`endif
            tests++;
            if (xfer_cyc[k] != exp_c || xfer_byte[k] !== exp_b) begin
                fails++;
                $display("FAIL rr_xfer[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                         k, xfer_byte[k], xfer_cyc[k], exp_b, exp_c);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_pkts();
        add_byte(2, 8'hAA, 1'b0);
        add_byte(2, 8'h55, 1'b1);
        rdy_pat.push_back(1'b1);
`ifdef ARB_HDR_EN
        rdy_pat.push_back(1'b1);
`endif
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        build_exp(0);
        run_stream(0, 2, -1);
        tests++;
        if (xfer_cyc.size() != 2 + H) begin
            fails++; $display("FAIL bp_count: got %0d expected %0d", xfer_cyc.size(), 2 + H);
        end else begin
            tests++;
            if (xfer_cyc[H] != 1 + H || xfer_cyc[H + 1] != 4 + H) begin
                fails++;
                $display("FAIL bp_timing: got cycles %0d,%0d expected %0d,%0d",
                         xfer_cyc[H], xfer_cyc[H + 1], 1 + H, 4 + H);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [7:0] eb[6];
        logic [1:0] ei[6];
        eb[0] = 8'h10; eb[1] = 8'h11; eb[2] = 8'h33; eb[3] = 8'h12; eb[4] = 8'h13; eb[5] = 8'h14;
        ei[0] = 2'd1;  ei[1] = 2'd1;  ei[2] = 2'd3;  ei[3] = 2'd1;  ei[4] = 2'd1;  ei[5] = 2'd1;
        do_reset();
        clear_pkts();
        for (int k = 0; k < 5; k++) add_byte(1, 8'h10 + 8'(k), k == 4);
        add_byte(3, 8'h33, 1'b1);
        build_exp(2);
        run_stream(1, 0, -1);
        tests++;
        if (data_byte.size() != 6) begin
            fails++; $display("FAIL burst_count: got %0d expected 6", data_byte.size());
        end
        for (int k = 0; k < data_byte.size() && k < 6; k++) begin
            tests++;
            if (data_byte[k] !== eb[k] || data_id[k] !== ei[k]) begin
                fails++;
                $display("FAIL burst_order[%0d]: got r%0d %h expected r%0d %h",
                         k, data_id[k], data_byte[k], ei[k], eb[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_pkts();
        for (int k = 0; k < 4; k++) add_byte(0, 8'h01 + 8'(k), k == 3);
        build_exp(0);
        run_stream(0, 0, 2 + H);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++; if (txv_a !== 1'b0)   begin fails++; $display("FAIL midrst_tx_valid: got %b expected 0", txv_a); end
        tests++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        tests++; if (rr_a !== 4'b0000) begin fails++; $display("FAIL midrst_req_ready: got %b expected 0000", rr_a); end
        rst = 1'b0;
        clear_pkts();
        for (int k = 0; k < 4; k++) add_byte(0, 8'h51 + 8'(k), k == 3);
        add_byte(1, 8'h61, 1'b1);
        build_exp(0);
        run_stream(0, 1, -1);
        tests++;
        if (data_id.size() == 0 || data_id[0] !== 2'd0) begin
            fails++; $display("FAIL midrst_next_grant: got %0d bytes / first id %0d expected first id 0",
                              data_id.size(), (data_id.size() == 0) ? -1 : int'(data_id[0]));
        end
    endtask

`ifdef ARB_HDR_EN
    task automatic test_hdr();
        do_reset();
        clear_pkts();
        add_byte(3, 8'h7E, 1'b1);
        build_exp(0);
        run_stream(0, 0, -1);
        tests++;
        if (xfer_byte.size() != 2 || xfer_byte[0] !== 8'hA3 || xfer_byte[1] !== 8'h7E) begin
            fails++; $display("FAIL hdr_sequence: got %0d bytes, expected A3 then 7E", xfer_byte.size());
        end else begin
            tests++;
            if (xfer_cyc[0] != 1 || xfer_cyc[1] != 2) begin
                fails++; $display("FAIL hdr_timing: got cycles %0d,%0d expected 1,2", xfer_cyc[0], xfer_cyc[1]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int sel;
        int np;
        int len;
        for (int r = 0; r < 8; r++) begin
            sel = r % 2;
            do_reset();
            clear_pkts();
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            build_exp(sel == 1 ? 2 : 0);
            run_stream(sel, 1, -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        clear_pkts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_burst_limit();
        test_reset_mid();
`ifdef ARB_HDR_EN
        test_hdr();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
